dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory bus arbiter: grants one of NUM_REQ requesters (router last) with
// round-robin fairness, a router priority override, a one-cycle turnaround gap and a hold timeout.
module dmem_arbiter #(
    parameter int  NUM_REQ  = 3,
    parameter int  MAX_HOLD = 64,
    localparam int OWNER_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               I_En,
    input  logic               I_Pri_Rt,
    input  logic [NUM_REQ-1:0] I_Req,
    input  logic [NUM_REQ-1:0] I_Rls,
    output logic [NUM_REQ-1:0] O_Grant,
    output logic [OWNER_W-1:0] O_Owner,
    output logic               O_Busy,
    output logic               O_Timeout,
    output logic               O_Err
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    localparam logic [OWNER_W-1:0] ROUTER_IDX = OWNER_W'(NUM_REQ - 1);
    localparam logic [15:0]        HOLD_LAST  = 16'(MAX_HOLD - 1);

    state_t               state_reg, state_next;
    logic [OWNER_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [OWNER_W-1:0]   owner_reg, owner_next;
    logic [15:0]          hold_reg, hold_next;
    logic [NUM_REQ-1:0]   grant_reg, grant_next;
    logic                 busy_reg, busy_next;
    logic                 timeout_reg, timeout_next;
    logic                 err_reg, err_next;

    logic [OWNER_W-1:0]   rot_idx [NUM_REQ];
    logic [NUM_REQ-1:0]   req_rot;
    logic [OWNER_W-1:0]   rr_win;
    logic [OWNER_W-1:0]   win;
    logic [OWNER_W-1:0]   owner_inc;
    logic                 rr_found;
    logic                 owner_rls;
    logic                 hold_expired;

    // Requests rotated so that position 0 is the requester at rr_ptr.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign rot_idx[gi] = OWNER_W'((int'(rr_ptr_reg) + gi) % NUM_REQ);
            assign req_rot[gi] = I_Req[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rr_found && req_rot[i]) begin
                rr_found = 1'b1;
                rr_win   = rot_idx[i];
            end
        end
    end

    assign win          = (I_Pri_Rt && I_Req[NUM_REQ-1]) ? ROUTER_IDX : rr_win;
    assign owner_inc    = OWNER_W'((int'(owner_reg) + 1) % NUM_REQ);
    assign owner_rls    = I_Rls[owner_reg] | ~I_Req[owner_reg];
    assign hold_expired = (hold_reg == HOLD_LAST);

    always_comb begin
        state_next   = state_reg;
        rr_ptr_next  = rr_ptr_reg;
        owner_next   = owner_reg;
        hold_next    = hold_reg;
        grant_next   = grant_reg;
        busy_next    = busy_reg;
        timeout_next = 1'b0;
        err_next     = err_reg;
        unique case (state_reg)
            GRANT: begin
                // Release takes precedence over a timeout landing on the same edge.
                if (owner_rls || hold_expired) begin
                    state_next   = GAP;
                    grant_next   = '0;
                    busy_next    = 1'b0;
                    rr_ptr_next  = owner_inc;
                    timeout_next = ~owner_rls;
                    err_next     = err_reg | ~owner_rls;
                end else begin
                    hold_next = hold_reg + 16'd1;
                end
            end
            default: begin
                if (I_En && rr_found) begin
                    state_next       = GRANT;
                    owner_next       = win;
                    grant_next       = '0;
                    grant_next[win]  = 1'b1;
                    busy_next        = 1'b1;
                    hold_next        = '0;
                end else begin
                    state_next = IDLE;
                    grant_next = '0;
                    busy_next  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= '0;
            owner_reg   <= '0;
            hold_reg    <= '0;
            grant_reg   <= '0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rr_ptr_reg  <= rr_ptr_next;
            owner_reg   <= owner_next;
            hold_reg    <= hold_next;
            grant_reg   <= grant_next;
            busy_reg    <= busy_next;
            timeout_reg <= timeout_next;
            err_reg     <= err_next;
        end
    end

    assign O_Grant   = grant_reg;
    assign O_Owner   = owner_reg;
    assign O_Busy    = busy_reg;
    assign O_Timeout = timeout_reg;
    assign O_Err     = err_reg;

endmodule
